cpu_mode_seq: RTL

Mode-change sequencer that sits directly upstream of the `CHIP CPU` instance and drives its `cmode` and `bclko` inputs. It synchronises and debounces an asynchronous mode request, stalls the CPU through a hold/ack handshake, flips `cmode` only after the CPU acknowledges, and generates the divided bus clock `bclko`, re-phased on every mode change.

---
 rtl/cpu_mode_pkg.sv | 16 +
 rtl/cpu_mode_seq_sync_bit.sv | 33 +++
 rtl/cpu_mode_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cpu_mode_pkg.sv
// Shared types and default parameter values for the CPU mode-change sequencer.
package cpu_mode_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        WAIT_ACK = 2'd2
    } cpu_mode_state_e;

    localparam int   BCLK_DIV_DEF     = 4;
    localparam int   SYNC_STAGES_DEF  = 2;
    localparam int   DEBOUNCE_CYC_DEF = 8;
    localparam int   ACK_TIMEOUT_DEF  = 16;
    localparam logic CMODE_RST_DEF    = 1'b0;

endpackage

// File: rtl/cpu_mode_seq_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level input; reusable for other CPU-side inputs.
module sync_bit
    import cpu_mode_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
    end

    // Chain register, preset to the reset level so no spurious request follows reset.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/cpu_mode_seq.sv
// Mode-change sequencer: debounces an async mode request, stalls the CPU via hold/ack,
// flips cmode on acknowledge and generates the re-phased divided bus clock.
module cpu_mode_seq
    import cpu_mode_pkg::*;
#(
    parameter int   BCLK_DIV     = BCLK_DIV_DEF,
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int   ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter logic CMODE_RST    = CMODE_RST_DEF
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic mode_req_i,
    input  logic mode_ack_i,
    output logic cmode,
    output logic bclko,
    output logic hold_o,
    output logic busy_o,
    output logic mode_chg_o,
    output logic err_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int BC_W = $clog2(BCLK_DIV + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BCLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(BCLK_DIV / 2);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    cpu_mode_state_e state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [BC_W-1:0] bc_cnt_q, bc_cnt_d;
    logic            cmode_q, cmode_d;
    logic            bclko_q, bclko_d;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            chg_q, chg_d;
    logic            err_q, err_d;
    logic            req_s;
    logic            mismatch_s;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CMODE_RST)
    ) u_req_sync (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .d_i    (mode_req_i),
        .q_o    (req_s)
    );

    assign mismatch_s = (req_s != cmode_q);

    // Next-state, counter and output computation for the request/handshake FSM.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        to_cnt_d = to_cnt_q;
        cmode_d  = cmode_q;
        chg_d    = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mismatch_s) begin
                    state_d  = DEBOUNCE;
                    db_cnt_d = {DB_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!mismatch_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = WAIT_ACK;
                    to_cnt_d = {TO_W{1'b0}};
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            WAIT_ACK: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (mode_ack_i) begin
                    cmode_d = ~cmode_q;
                    chg_d   = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        hold_d = (state_d == WAIT_ACK);
        busy_d = (state_d != IDLE);

        // A mode change discards the old bus-clock phase, partial period included.
        if (chg_d) begin
            bc_cnt_d = {BC_W{1'b0}};
        end else if (bc_cnt_q == BC_LAST) begin
            bc_cnt_d = {BC_W{1'b0}};
        end else begin
            bc_cnt_d = bc_cnt_q + BC_ONE;
        end
        bclko_d = (bc_cnt_d < BC_HALF);
    end

    // State, counter and registered-output flops.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            db_cnt_q <= {DB_W{1'b0}};
            to_cnt_q <= {TO_W{1'b0}};
            bc_cnt_q <= {BC_W{1'b0}};
            cmode_q  <= CMODE_RST;
            bclko_q  <= 1'b0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            to_cnt_q <= to_cnt_d;
            bc_cnt_q <= bc_cnt_d;
            cmode_q  <= cmode_d;
            bclko_q  <= bclko_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            chg_q    <= chg_d;
            err_q    <= err_d;
        end
    end

    assign cmode      = cmode_q;
    assign bclko      = bclko_q;
    assign hold_o     = hold_q;
    assign busy_o     = busy_q;
    assign mode_chg_o = chg_q;
    assign err_o      = err_q;

endmodule
